instr_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the decoder: owns the program counter, reads 16-bit instruction words from the instruction ROM, and buffers them in a small prefetch FIFO. Words are handed to the decode stage over a valid/ready handshake, tagged with their PC. Supports redirect with flush, and stops fetching after a halt word.

---
 rtl/instr_fetch_unit_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   INSTR_WIDTH       : instruction word width
//   DEFAULT_HALT_WORD : encoding that stops fetching
//   fetch_state_t     : fetch FSM states
package instr_fetch_unit_pkg;

    localparam int unsigned INSTR_WIDTH = 16;

    localparam logic [INSTR_WIDTH-1:0] DEFAULT_HALT_WORD = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH x WIDTH registered storage with synchronous flush.
// Ports:
//   clk, rst (sync active-low)  clock / reset, reset zeroes storage
//   flush                       empty the FIFO (pointers and count to 0)
//   push, wdata                 write one entry
//   pop                         retire the head entry
//   rdata, valid                head entry and non-empty flag
//   count                       entries held
// Push and pop in the same cycle are legal even when full.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign rdata = mem[rd_ptr];
    assign valid = (count != '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction ROM and feeds
// the decoder through a prefetch FIFO with a valid/ready handshake.
// Ports:
//   clk, rst (sync active-low)   clock / reset
//   start                        leave IDLE and begin fetching
//   redirect_valid, redirect_pc  flush FIFO and restart at redirect_pc
//   rom_addr, rom_ce, rom_data   ROM interface (rom_addr/rom_ce combinational)
//   instr_valid/ready/data/pc    decoder handshake, head word tagged with PC
//   fifo_count                   buffered entries
//   halted                       fetch stopped after a halt word
//   issued_count                 words accepted by the decoder
// Optional feature macro: FETCH_PERF_EN enables the issued_count counter;
// without it issued_count is tied to zero.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned                 ADDR_WIDTH = 3,
    parameter int unsigned                 DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0]       RESET_PC   = '0,
    parameter logic [INSTR_WIDTH-1:0]      HALT_WORD  = DEFAULT_HALT_WORD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     redirect_valid,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc,
    output logic [ADDR_WIDTH-1:0]    rom_addr,
    output logic                     rom_ce,
    input  logic [INSTR_WIDTH-1:0]   rom_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_WIDTH-1:0]   instr_data,
    output logic [ADDR_WIDTH-1:0]    instr_pc,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     halted,
    output logic [15:0]              issued_count
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = INSTR_WIDTH + ADDR_WIDTH;

    fetch_state_t            state;
    fetch_state_t            state_next;
    logic [ADDR_WIDTH-1:0]   pc;
    logic                    fetch;
    logic                    pop;
    logic [ENTRY_W-1:0]      head;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; redirect overrides everything and always lands in RUN.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = RUN;
        end else begin
            case (state)
                IDLE:    if (start) state_next = RUN;
                RUN:     if (fetch && (rom_data == HALT_WORD)) state_next = HALTED;
                default: state_next = state;
            endcase
        end
    end

    // Outputs: a pop in the same cycle frees a slot, so a full FIFO keeps fetching.
    always_comb begin
        pop      = instr_valid & instr_ready & ~redirect_valid;
        fetch    = (state == RUN) & ~redirect_valid &
                   ((fifo_count < CNT_W'(DEPTH)) | pop);
        rom_ce   = fetch;
        rom_addr = pc;
    end

    // Program counter; wraps modulo 2^ADDR_WIDTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (fetch) begin
            pc <= pc + ADDR_WIDTH'(1);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (fetch),
        .wdata ({rom_data, pc}),
        .pop   (pop),
        .rdata (head),
        .valid (instr_valid),
        .count (fifo_count)
    );

    assign instr_data = head[ENTRY_W-1 -: INSTR_WIDTH];
    assign instr_pc   = head[ADDR_WIDTH-1:0];
    assign halted     = (state == HALTED);

`ifdef FETCH_PERF_EN
    // Decoder acceptance counter; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            issued_count <= '0;
        end else if (pop) begin
            issued_count <= issued_count + 16'd1;
        end
    end
`else
    assign issued_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (ADDR_WIDTH=3, DEPTH=4).
module tb_instr_fetch_unit;

    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 4;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk            = 1'b0;
    logic          rst            = 1'b0;
    logic          start          = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc    = '0;
    logic          instr_ready    = 1'b0;
    logic [AW-1:0] rom_addr;
    logic          rom_ce;
    logic [15:0]   rom_data;
    logic          instr_valid;
    logic [15:0]   instr_data;
    logic [AW-1:0] instr_pc;
    logic [2:0]    fifo_count;
    logic          halted;
    logic [15:0]   issued_count;

    logic [15:0]   rom [8];

    int n_cmp = 0;
    int n_err = 0;

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .RESET_PC   (3'd0),
        .HALT_WORD  (16'hFFFF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_addr       (rom_addr),
        .rom_ce         (rom_ce),
        .rom_data       (rom_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .fifo_count     (fifo_count),
        .halted         (halted),
        .issued_count   (issued_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_at(input int i);
        return 32'(16'h5A00 | 16'(i));
    endfunction

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_valid"},  32'(instr_valid),  32'd0);
        chk({pfx, "_data"},   32'(instr_data),   32'd0);
        chk({pfx, "_pc"},     32'(instr_pc),     32'd0);
        chk({pfx, "_count"},  32'(fifo_count),   32'd0);
        chk({pfx, "_halted"}, 32'(halted),       32'd0);
        chk({pfx, "_ce"},     32'(rom_ce),       32'd0);
        chk({pfx, "_addr"},   32'(rom_addr),     32'd0);
        chk({pfx, "_issued"}, 32'(issued_count), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rom[i] = 16'hAAAA;
        rom[0] = 16'h1111;
        rom[1] = 16'h2222;
        rom[2] = 16'hFFFF;

        // Reset
        tick();
        tick();
        chk_reset_values("reset");

        // Start, stream three words ending with the halt word
        rst = 1'b1; start = 1'b1; instr_ready = 1'b1;
        #1;
        chk("idle_ce", 32'(rom_ce), 32'd0);
        tick(); start = 1'b0;
        #1;
        chk("start_ce",    32'(rom_ce),      32'd1);
        chk("start_addr",  32'(rom_addr),    32'd0);
        chk("start_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("w0_valid", 32'(instr_valid), 32'd1);
        chk("w0_data",  32'(instr_data),  32'h1111);
        chk("w0_pc",    32'(instr_pc),    32'd0);
        tick();
        chk("w1_data",  32'(instr_data),  32'h2222);
        chk("w1_pc",    32'(instr_pc),    32'd1);
        chk("w1_count", 32'(fifo_count),  32'd1);
        tick();
        chk("w2_data",   32'(instr_data), 32'hFFFF);
        chk("w2_pc",     32'(instr_pc),   32'd2);
        chk("w2_halted", 32'(halted),     32'd1);
        chk("w2_ce",     32'(rom_ce),     32'd0);
        tick();
        chk("drain_valid",  32'(instr_valid), 32'd0);
        chk("drain_count",  32'(fifo_count),  32'd0);
        chk("halt_ce",      32'(rom_ce),      32'd0);
        chk("halt_hold",    32'(halted),      32'd1);
        tick();
        chk("halt_ce2",     32'(rom_ce),      32'd0);

        // Redirect out of HALTED, then stall the decoder until full
        for (int i = 0; i < 8; i++) rom[i] = 16'(word_at(i));
        instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 3'd0;
        #1;
        chk("redir_ce_off", 32'(rom_ce), 32'd0);
        tick(); redirect_valid = 1'b0;
        #1;
        chk("redir_halted", 32'(halted),     32'd0);
        chk("redir_count",  32'(fifo_count), 32'd0);
        chk("redir_ce",     32'(rom_ce),     32'd1);
        chk("redir_addr",   32'(rom_addr),   32'd0);
        tick(); tick(); tick(); tick();
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_ce",    32'(rom_ce),     32'd0);
        chk("full_addr",  32'(rom_addr),   32'd4);
        chk("full_head",  32'(instr_pc),   32'd0);
        tick();
        chk("stall_count", 32'(fifo_count), 32'd4);
        chk("stall_head",  32'(instr_pc),   32'd0);
        chk("stall_data",  32'(instr_data), word_at(0));

        // Release: push and pop each cycle while full, PC wraps 7 -> 0
        instr_ready = 1'b1;
        #1;
        chk("full_pop_ce", 32'(rom_ce), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("thru_count", 32'(fifo_count), 32'd4);
            chk("thru_pc",    32'(instr_pc),   32'(i));
            chk("thru_data",  32'(instr_data), word_at(i));
            chk("thru_addr",  32'(rom_addr),   32'((4 + i) % 8));
        end

        // Flush, buffer three words, redirect to 5 with ready high
        instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 3'd0;
        tick(); redirect_valid = 1'b0;
        chk("flush_count", 32'(fifo_count), 32'd0);
        tick(); tick(); tick();
        chk("three_count", 32'(fifo_count), 32'd3);
        chk("three_head",  32'(instr_pc),   32'd0);
        redirect_valid = 1'b1; redirect_pc = 3'd5; instr_ready = 1'b1;
        #1;
        chk("r5_ce_off", 32'(rom_ce), 32'd0);
        tick(); redirect_valid = 1'b0;
        #1;
        chk("r5_count", 32'(fifo_count),  32'd0);
        chk("r5_valid", 32'(instr_valid), 32'd0);
        chk("r5_ce",    32'(rom_ce),      32'd1);
        chk("r5_addr",  32'(rom_addr),    32'd5);
        tick();
        chk("r5_valid2", 32'(instr_valid), 32'd1);
        chk("r5_pc",     32'(instr_pc),    32'd5);
        chk("r5_data",   32'(instr_data),  word_at(5));
        tick();
        chk("r6_pc",    32'(instr_pc),   32'd6);
        chk("r6_data",  32'(instr_data), word_at(6));
        chk("r6_count", 32'(fifo_count), 32'd1);
        chk("issued_pre_reset", 32'(issued_count), PERF ? 32'd9 : 32'd0);

        // Reset mid-operation discards everything
        rst = 1'b0;
        tick();
        chk_reset_values("midrst");
        rst = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
